// File: rtl/game_pkg.sv
// Shared game definitions: end-screen state encoding and default timing.
package game_pkg;

  typedef enum logic [1:0] {
    PLAY    = 2'd0,
    BLINK   = 2'd1,
    LOCKOUT = 2'd2,
    READY   = 2'd3
  } end_state_t;

  localparam int BLINK_FRAMES_DEF = 15;
  localparam int BLINK_COUNT_DEF  = 4;
  localparam int HOLD_FRAMES_DEF  = 120;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/end_text_sequencer_if.sv
// Event inputs and overlay/freeze outputs of the end-text sequencer.
interface end_text_sequencer_if;
  logic frame_tick;
  logic lose_evt;
  logic win_evt;
  logic restart;
  logic show_lose_text;
  logic show_win_text;
  logic game_freeze;
  logic restart_ready;

  modport master (
    output frame_tick, lose_evt, win_evt, restart,
    input  show_lose_text, show_win_text, game_freeze, restart_ready
  );

  modport slave (
    input  frame_tick, lose_evt, win_evt, restart,
    output show_lose_text, show_win_text, game_freeze, restart_ready
  );
endinterface

// File: rtl/end_text_sequencer_frame_counter.sv
// Frame-tick counter with terminal-count hit; self-clears on hit.
module frame_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         hit
);
  logic [W-1:0] cnt;

  // hit fires on the enabled tick that lands on the terminal count
  assign hit = en && (cnt == term);

  // count enabled ticks, restart from zero on hit or clear
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= hit ? '0 : cnt + W'(1);
    end
  end
endmodule

// File: rtl/end_text_sequencer.sv
// End-of-game overlay sequencer: blink, hold, then accept restart.
//
// state   | meaning
// PLAY    | no overlay, gameplay running
// BLINK   | overlay blinking, frame counter paces half-periods
// LOCKOUT | overlay steady, restart still refused
// READY   | overlay steady, restart accepted
module end_text_sequencer
  import game_pkg::*;
#(
  parameter int BLINK_FRAMES = BLINK_FRAMES_DEF,
  parameter int BLINK_COUNT  = BLINK_COUNT_DEF,
  parameter int HOLD_FRAMES  = HOLD_FRAMES_DEF
) (
  input logic Clk,
  input logic Reset,
  end_text_sequencer_if.slave bus
);
  localparam int FW = $clog2(max_int(BLINK_FRAMES, HOLD_FRAMES) + 1);
  localparam int PW = $clog2(2 * BLINK_COUNT + 1);
  localparam logic [FW-1:0] BLINK_TERM = FW'(BLINK_FRAMES - 1);
  localparam logic [FW-1:0] HOLD_TERM  = FW'(HOLD_FRAMES - 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(2 * BLINK_COUNT - 1);

  end_state_t    state, state_nxt;
  logic          visible, vis_nxt;
  logic          res_win, res_nxt;
  logic [PW-1:0] phase_cnt, phase_nxt;
  logic          cnt_clear, cnt_en, cnt_hit;
  logic [FW-1:0] cnt_term;

  frame_counter #(.W(FW)) u_frame_counter (
    .clk   (Clk),
    .rst   (Reset),
    .clear (cnt_clear),
    .en    (cnt_en),
    .term  (cnt_term),
    .hit   (cnt_hit)
  );

  // next state, blink phase and counter control
  always_comb begin
    state_nxt = state;
    vis_nxt   = visible;
    res_nxt   = res_win;
    phase_nxt = phase_cnt;
    cnt_en    = 1'b0;
    cnt_term  = BLINK_TERM;
    case (state)
      PLAY: begin
        vis_nxt   = 1'b0;
        phase_nxt = '0;
        if (bus.lose_evt || bus.win_evt) begin
          state_nxt = BLINK;
          vis_nxt   = 1'b1;
          res_nxt   = bus.win_evt && !bus.lose_evt;
        end
      end
      BLINK: begin
        cnt_en = bus.frame_tick;
        if (cnt_hit) begin
          vis_nxt = !visible;
          if (phase_cnt == PHASE_LAST) begin
            state_nxt = LOCKOUT;
            phase_nxt = '0;
          end else begin
            phase_nxt = phase_cnt + PW'(1);
          end
        end
      end
      LOCKOUT: begin
        cnt_en   = bus.frame_tick;
        cnt_term = HOLD_TERM;
        vis_nxt  = 1'b1;
        if (cnt_hit) state_nxt = READY;
      end
      READY: begin
        vis_nxt = 1'b1;
        if (bus.restart) begin
          state_nxt = PLAY;
          vis_nxt   = 1'b0;
          res_nxt   = 1'b0;
        end
      end
      default: state_nxt = PLAY;
    endcase
    // a state change always starts the next phase from a zero count
    cnt_clear = (state_nxt != state) || (state == PLAY);
  end

  // state, blink and result registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= PLAY;
      visible   <= 1'b0;
      res_win   <= 1'b0;
      phase_cnt <= '0;
    end else begin
      state     <= state_nxt;
      visible   <= vis_nxt;
      res_win   <= res_nxt;
      phase_cnt <= phase_nxt;
    end
  end

  // outputs are flopped from next-state values so they move with the state
  always_ff @(posedge Clk) begin
    if (Reset) begin
      bus.show_lose_text <= 1'b0;
      bus.show_win_text  <= 1'b0;
      bus.game_freeze    <= 1'b0;
      bus.restart_ready  <= 1'b0;
    end else begin
      bus.show_lose_text <= vis_nxt && !res_nxt;
      bus.show_win_text  <= vis_nxt && res_nxt;
      bus.game_freeze    <= (state_nxt != PLAY);
      bus.restart_ready  <= (state_nxt == READY);
    end
  end
endmodule

// File: tb/tb_end_text_sequencer.sv
// Bench for end_text_sequencer: expected output vectors are queued as
// stimulus is driven and compared when the DUT answers.
module tb_end_text_sequencer;
  localparam int BF = 2;
  localparam int BC = 2;
  localparam int HF = 3;
  localparam int BLINK_T = 2 * BC * BF;
  localparam int DONE_T  = BLINK_T + HF;

  logic Clk = 1'b0;
  logic Reset;
  int checks = 0;
  int errors = 0;
  logic [3:0] sb[$];

  end_text_sequencer_if bus();

  end_text_sequencer #(
    .BLINK_FRAMES(BF), .BLINK_COUNT(BC), .HOLD_FRAMES(HF)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  // {show_lose, show_win, freeze, ready}
  function automatic logic [3:0] outs();
    return {bus.show_lose_text, bus.show_win_text, bus.game_freeze, bus.restart_ready};
  endfunction

  // expected vector k ticks after an event (k=0: cycle after the event)
  function automatic logic [3:0] exp_vec(input int k, input bit win);
    logic vis, rdy;
    vis = (k >= BLINK_T) ? 1'b1 : (((k / BF) % 2) == 0);
    rdy = (k >= DONE_T);
    return {vis & ~win, vis & win, 1'b1, rdy};
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic tick();
    bus.frame_tick = 1'b1;
    cyc(1);
    bus.frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] e;
    Reset = 1'b1;
    sb.push_back(4'b0000);
    cyc(2);
    e = sb.pop_front(); checks++;
    if (outs() !== e) begin errors++; $display("FAIL reset got=%b want=%b", outs(), e); end
    Reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sb.push_back(4'b0000);
      tick();
      e = sb.pop_front(); checks++;
      if (outs() !== e) begin errors++; $display("FAIL idle_tick%0d got=%b want=%b", i, outs(), e); end
      cyc(9);
    end
  endtask

  task automatic test_lose_sequence();
    logic [3:0] e;
    bus.lose_evt = 1'b1;
    sb.push_back(exp_vec(0, 1'b0));
    cyc(1);
    bus.lose_evt = 1'b0;
    e = sb.pop_front(); checks++;
    if (outs() !== e) begin errors++; $display("FAIL lose_entry got=%b want=%b", outs(), e); end
    cyc(3);
    for (int k = 1; k <= DONE_T; k++) begin
      sb.push_back(exp_vec(k, 1'b0));
      tick();
      e = sb.pop_front(); checks++;
      if (outs() !== e) begin errors++; $display("FAIL lose_tick%0d got=%b want=%b", k, outs(), e); end
      cyc(9);
    end
    bus.restart = 1'b1;
    sb.push_back(4'b0000);
    cyc(1);
    bus.restart = 1'b0;
    e = sb.pop_front(); checks++;
    if (outs() !== e) begin errors++; $display("FAIL lose_restart got=%b want=%b", outs(), e); end
    cyc(4);
  endtask

  task automatic test_simultaneous();
    logic [3:0] e;
    bus.lose_evt = 1'b1;
    bus.win_evt  = 1'b1;
    sb.push_back(exp_vec(0, 1'b0));
    cyc(1);
    bus.lose_evt = 1'b0;
    bus.win_evt  = 1'b0;
    e = sb.pop_front(); checks++;
    if (outs() !== e) begin errors++; $display("FAIL simul_entry got=%b want=%b", outs(), e); end
    cyc(3);
    for (int k = 1; k <= DONE_T; k++) begin
      sb.push_back(exp_vec(k, 1'b0));
      tick();
      e = sb.pop_front(); checks++;
      if (outs() !== e) begin errors++; $display("FAIL simul_tick%0d got=%b want=%b", k, outs(), e); end
      cyc(9);
    end
    bus.restart = 1'b1;
    cyc(1);
    bus.restart = 1'b0;
    cyc(4);
  endtask

  task automatic test_early_restart();
    logic [3:0] e;
    bus.win_evt = 1'b1;
    sb.push_back(exp_vec(0, 1'b1));
    cyc(1);
    bus.win_evt = 1'b0;
    e = sb.pop_front(); checks++;
    if (outs() !== e) begin errors++; $display("FAIL win_entry got=%b want=%b", outs(), e); end
    cyc(3);
    for (int k = 1; k <= DONE_T; k++) begin
      // restart coincident with the READY-entry tick must be ignored
      if (k == DONE_T) bus.restart = 1'b1;
      sb.push_back(exp_vec(k, 1'b1));
      tick();
      bus.restart = 1'b0;
      e = sb.pop_front(); checks++;
      if (outs() !== e) begin errors++; $display("FAIL win_tick%0d got=%b want=%b", k, outs(), e); end
      cyc(2);
      if (k == 3 || k == BLINK_T + 1) begin
        bus.restart = 1'b1;
        sb.push_back(exp_vec(k, 1'b1));
        cyc(1);
        bus.restart = 1'b0;
        e = sb.pop_front(); checks++;
        if (outs() !== e) begin errors++; $display("FAIL early_restart_k%0d got=%b want=%b", k, outs(), e); end
      end else begin
        cyc(1);
      end
      cyc(6);
    end
    bus.restart = 1'b1;
    sb.push_back(4'b0000);
    cyc(1);
    bus.restart = 1'b0;
    e = sb.pop_front(); checks++;
    if (outs() !== e) begin errors++; $display("FAIL ready_restart got=%b want=%b", outs(), e); end
    cyc(3);
    sb.push_back(4'b0000);
    tick();
    e = sb.pop_front(); checks++;
    if (outs() !== e) begin errors++; $display("FAIL play_after_restart got=%b want=%b", outs(), e); end
    cyc(5);
  endtask

  task automatic test_events_off_play();
    logic [3:0] e;
    bus.win_evt = 1'b1;
    sb.push_back(exp_vec(0, 1'b1));
    cyc(1);
    bus.win_evt = 1'b0;
    e = sb.pop_front(); checks++;
    if (outs() !== e) begin errors++; $display("FAIL off_entry got=%b want=%b", outs(), e); end
    cyc(3);
    for (int k = 1; k <= DONE_T; k++) begin
      sb.push_back(exp_vec(k, 1'b1));
      tick();
      e = sb.pop_front(); checks++;
      if (outs() !== e) begin errors++; $display("FAIL off_tick%0d got=%b want=%b", k, outs(), e); end
      cyc(2);
      if (k == 1 || k == BLINK_T + 1 || k == DONE_T) begin
        bus.lose_evt = 1'b1;
        sb.push_back(exp_vec(k, 1'b1));
        cyc(1);
        bus.lose_evt = 1'b0;
        e = sb.pop_front(); checks++;
        if (outs() !== e) begin errors++; $display("FAIL off_lose_k%0d got=%b want=%b", k, outs(), e); end
      end else begin
        cyc(1);
      end
      cyc(6);
    end
    // restart wins over a coincident event in READY
    bus.restart  = 1'b1;
    bus.lose_evt = 1'b1;
    sb.push_back(4'b0000);
    sb.push_back(4'b0000);
    cyc(1);
    bus.restart  = 1'b0;
    bus.lose_evt = 1'b0;
    e = sb.pop_front(); checks++;
    if (outs() !== e) begin errors++; $display("FAIL restart_vs_evt got=%b want=%b", outs(), e); end
    cyc(1);
    e = sb.pop_front(); checks++;
    if (outs() !== e) begin errors++; $display("FAIL evt_dropped got=%b want=%b", outs(), e); end
    cyc(3);
    // event with a coincident tick: that tick must not count
    bus.lose_evt   = 1'b1;
    bus.frame_tick = 1'b1;
    sb.push_back(exp_vec(0, 1'b0));
    cyc(1);
    bus.lose_evt   = 1'b0;
    bus.frame_tick = 1'b0;
    e = sb.pop_front(); checks++;
    if (outs() !== e) begin errors++; $display("FAIL evt_tick_entry got=%b want=%b", outs(), e); end
    cyc(9);
    for (int k = 1; k <= DONE_T; k++) begin
      sb.push_back(exp_vec(k, 1'b0));
      tick();
      e = sb.pop_front(); checks++;
      if (outs() !== e) begin errors++; $display("FAIL evt_tick_k%0d got=%b want=%b", k, outs(), e); end
      cyc(9);
    end
    bus.restart = 1'b1;
    cyc(1);
    bus.restart = 1'b0;
    cyc(4);
  endtask

  task automatic test_reset_mid();
    logic [3:0] e;
    bus.lose_evt = 1'b1;
    sb.push_back(exp_vec(0, 1'b0));
    cyc(1);
    bus.lose_evt = 1'b0;
    e = sb.pop_front(); checks++;
    if (outs() !== e) begin errors++; $display("FAIL mid_entry got=%b want=%b", outs(), e); end
    cyc(3);
    for (int k = 1; k <= BLINK_T + 1; k++) begin
      sb.push_back(exp_vec(k, 1'b0));
      tick();
      e = sb.pop_front(); checks++;
      if (outs() !== e) begin errors++; $display("FAIL mid_tick%0d got=%b want=%b", k, outs(), e); end
      cyc(9);
    end
    Reset = 1'b1;
    sb.push_back(4'b0000);
    cyc(1);
    Reset = 1'b0;
    e = sb.pop_front(); checks++;
    if (outs() !== e) begin errors++; $display("FAIL mid_reset got=%b want=%b", outs(), e); end
    cyc(2);
    bus.win_evt = 1'b1;
    sb.push_back(exp_vec(0, 1'b1));
    cyc(1);
    bus.win_evt = 1'b0;
    e = sb.pop_front(); checks++;
    if (outs() !== e) begin errors++; $display("FAIL post_reset_entry got=%b want=%b", outs(), e); end
    cyc(3);
    for (int k = 1; k <= DONE_T; k++) begin
      sb.push_back(exp_vec(k, 1'b1));
      tick();
      e = sb.pop_front(); checks++;
      if (outs() !== e) begin errors++; $display("FAIL post_reset_tick%0d got=%b want=%b", k, outs(), e); end
      cyc(9);
    end
    bus.restart = 1'b1;
    sb.push_back(4'b0000);
    cyc(1);
    bus.restart = 1'b0;
    e = sb.pop_front(); checks++;
    if (outs() !== e) begin errors++; $display("FAIL post_reset_restart got=%b want=%b", outs(), e); end
  endtask

  initial begin
    Reset          = 1'b1;
    bus.frame_tick = 1'b0;
    bus.lose_evt   = 1'b0;
    bus.win_evt    = 1'b0;
    bus.restart    = 1'b0;
    cyc(1);
    test_reset();
    test_lose_sequence();
    test_simultaneous();
    test_early_restart();
    test_events_off_play();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/end_text_sequencer.md
# end_text_sequencer

- Sequences the end-of-game text overlays: decides when the "GAME OVER" and "WIN" sprites are enabled, blinks them, then holds them steady.
- Freezes gameplay while an overlay is up and accepts a restart only after a minimum display time.
- Sits between game logic (collision/score events, keyboard restart) and the colour mapper. Its enables gate `is_lose_text` / `is_win_text` before pixel colouring.
- All timing is counted in frames from a one-cycle frame tick.

## Interface

Parameters:
- `BLINK_FRAMES`, default 15: frames per blink half-period (on or off phase); must be ≥1.
- `BLINK_COUNT`, default 4: number of full on/off blinks before the text goes steady; must be ≥1.
- `HOLD_FRAMES`, default 120: frames of steady display before restart is accepted; must be ≥1.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `Clk`  in  1: 50 MHz system clock.
  - `Reset`  in  1: synchronous, active-high reset.
- Inputs:
  - `frame_tick`  in  1: one-`Clk` pulse per frame, synchronous to `Clk`.
  - `lose_evt`  in  1: one-cycle pulse, player lost.
  - `win_evt`  in  1: one-cycle pulse, player won.
  - `restart`  in  1: one-cycle pulse, restart key pressed.
- Outputs:
  - `show_lose_text`  out  1: enable for the GAME OVER overlay.
  - `show_win_text`  out  1: enable for the WIN overlay.
  - `game_freeze`  out  1: high while any end screen is active.
  - `restart_ready`  out  1: high when restart will be accepted.

## Operation

- States:
  - PLAY: no overlay; `game_freeze`=0.
  - BLINK: overlay blinking.
  - LOCKOUT: overlay steady, restart not yet accepted.
  - READY: overlay steady, restart accepted.
- Result register `res_win`, 1 bit: latched on entry to BLINK.
  - `show_lose_text` = visible & !res_win.
  - `show_win_text` = visible & res_win.
- PLAY:
  - `lose_evt` or `win_evt` → BLINK. `res_win` = win_evt & !lose_evt (lose has priority when both are high in the same cycle).
  - Entry to BLINK clears both counters and sets visible=1.
- BLINK:
  - Each `frame_tick` increments `frame_cnt`.
  - When `frame_cnt` reaches `BLINK_FRAMES`-1 on a tick: visible toggles, `frame_cnt` clears, `phase_cnt` increments.
  - After 2·`BLINK_COUNT` toggles, visible is back at 1. On that same tick, go to LOCKOUT with `frame_cnt` cleared.
- LOCKOUT:
  - visible=1.
  - On the `HOLD_FRAMES`-th tick → READY.
- READY:
  - visible=1, `restart_ready`=1.
  - `restart` → PLAY; visible=0, `res_win`=0.
- Ignored inputs:
  - `lose_evt`/`win_evt` in any state other than PLAY.
  - `restart` in any state other than READY.
  - `frame_tick` in PLAY.
- `game_freeze`=1 in BLINK, LOCKOUT and READY.
- Counter widths:
  - `frame_cnt`: $clog2(max(`BLINK_FRAMES`,`HOLD_FRAMES`)+1).
  - `phase_cnt`: $clog2(2·`BLINK_COUNT`+1).
  - Counters never wrap; they are cleared on every state transition.

## Timing

- All outputs are registered.
- Reset values: state=PLAY; all outputs 0; counters 0; `res_win`=0.
- Reset asserted mid-screen returns to PLAY on the next edge, regardless of state.
- Event in cycle t → `show_*_text`=1 and `game_freeze`=1 in cycle t+1.
- Blink toggle: output changes in the cycle after the qualifying `frame_tick`.
- BLINK duration: exactly 2·`BLINK_COUNT`·`BLINK_FRAMES` ticks.
- LOCKOUT duration: exactly `HOLD_FRAMES` ticks. `restart_ready` rises the cycle after the last of those ticks.
- `restart` in cycle t (in READY) → all outputs 0 in t+1.
- `restart` coincident with the READY-entry tick is ignored, because the state is still LOCKOUT.
- Event and `frame_tick` in the same PLAY cycle: the event is taken and that tick is not counted.
- `restart` and `lose_evt` in the same READY cycle: restart is taken and the event is dropped.

## Structure

- Shared game package `game_pkg`:
  - state enum `end_state_t` {PLAY, BLINK, LOCKOUT, READY}.
  - default constants `BLINK_FRAMES_DEF`, `BLINK_COUNT_DEF`, `HOLD_FRAMES_DEF`.
- One natural sub-module, `frame_counter`: a frame-tick counter with `clear`, `en`, and a `hit` output at a programmable terminal count. It is instantiated once and shared across BLINK and LOCKOUT.
- FSM next-state and output logic are kept in the top module.

## Test plan

Bench parameters: `BLINK_FRAMES`=2, `BLINK_COUNT`=2, `HOLD_FRAMES`=3; `frame_tick` every 10 cycles.

- **Reset:** Reset for 2 cycles → all outputs 0; 20 ticks with no events → outputs stay 0.
- **Lose sequence:** `lose_evt` pulse → `show_lose_text`=1 and `game_freeze`=1 next cycle. Visible pattern per tick pair is 1,0,1,0 then 1 steady. `restart_ready`=1 after 8+3=11 ticks. `show_win_text` stays 0 throughout.
- **Simultaneous events:** `lose_evt` and `win_evt` in the same cycle → lose screen (`show_lose_text`=1, `show_win_text`=0).
- **Early restart ignored:** `win_evt`, then `restart` during BLINK and again during LOCKOUT → ignored; outputs continue the sequence unchanged. `restart` in READY → all outputs 0 next cycle.
- **Events ignored off-PLAY:** `lose_evt` during a WIN screen → `show_win_text` unaffected and timing unchanged.
- **Reset mid-operation:** Reset asserted in LOCKOUT → all outputs 0 next cycle. A subsequent `win_evt` restarts a full 8-tick blink.
